// File: rtl/trace_capture_monitor.sv
// trace_capture_monitor
//   On-chip execution-trace capture for the RISC core. Retired instructions
//   are written into a circular buffer while armed. Capture stops POST_TRIG
//   entries after a PC breakpoint or a detected self-loop stall. The buffer
//   is then read out oldest-first.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   arm        in   pulse: clear buffer state and start capture (highest priority)
//   trig_en    in   enable PC breakpoint
//   trig_pc    in   breakpoint PC
//   cpu_valid  in   instruction retired this cycle
//   cpu_pc     in   PC of retired instruction
//   cpu_instr  in   retired instruction
//   cpu_rwe    in   retired instruction wrote a register
//   cpu_wdata  in   register write data
//   rd_req     in   request next trace entry (honoured only in DONE)
//   rd_data    out  {cpu_rwe, cpu_pc, cpu_instr, cpu_wdata}; holds when rd_valid=0
//   rd_valid   out  one-cycle pulse, rd_data valid
//   rd_last    out  qualifies rd_valid: final entry
//   busy       out  state PRE or POST
//   triggered  out  trigger seen since arm
//   stall      out  trigger source was stall detection
//   done       out  capture complete, readout available
//   count      out  valid entries remaining in buffer
//   dbg_state  out  FSM state (IDLE=0, PRE=1, POST=2, DONE=3)
//
// Readout handshake: in DONE, a cycle with rd_req=1 and entries remaining
// returns exactly one entry with rd_valid=1 on the following cycle (latency
// 1). rd_req held high streams one entry per cycle. rd_req is ignored in
// any other state and once the final (rd_last) entry has been issued.

module trace_capture_monitor #(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 16,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 4,
  parameter int STALL_LIMIT = 8,
  localparam int ENTRY_W    = 1 + PC_W + INSTR_W + DATA_W,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               cpu_valid,
  input  logic [PC_W-1:0]    cpu_pc,
  input  logic [INSTR_W-1:0] cpu_instr,
  input  logic               cpu_rwe,
  input  logic [DATA_W-1:0]  cpu_wdata,
  input  logic               rd_req,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               rd_last,
  output logic               busy,
  output logic               triggered,
  output logic               stall,
  output logic               done,
  output logic [CW-1:0]      count,
  output logic [1:0]         dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT);

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
  localparam logic [AW-1:0] POST_ONE  = AW'(1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        post_left_q, post_left_d;
  logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]      last_pc_q, last_pc_d;
  logic                 last_pc_vld_q, last_pc_vld_d;
  logic                 triggered_q, triggered_d;
  logic                 stall_q, stall_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 rd_last_q, rd_last_d;
  logic [ENTRY_W-1:0]   rd_data_q, rd_data_d;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic                 mem_we;
  logic [ENTRY_W-1:0]   wr_entry;

  logic                 pc_match;
  logic [SW-1:0]        stall_cnt_nxt;
  logic                 stall_hit;
  logic                 bp_hit;

  assign wr_entry = {cpu_rwe, cpu_pc, cpu_instr, cpu_wdata};

  // The first retire after arm has no valid predecessor, so it never matches.
  assign pc_match = last_pc_vld_q && (cpu_pc == last_pc_q);
  assign bp_hit   = trig_en && (cpu_pc == trig_pc);

  always_comb begin
    stall_cnt_nxt = '0;
    if (pc_match) begin
      // Saturate so a long self-loop during POST cannot wrap the counter.
      stall_cnt_nxt = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 1'b1;
    end
  end

  assign stall_hit = pc_match && (stall_cnt_nxt == STALL_MAX);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    post_left_d   = post_left_q;
    stall_cnt_d   = stall_cnt_q;
    last_pc_d     = last_pc_q;
    last_pc_vld_d = last_pc_vld_q;
    triggered_d   = triggered_q;
    stall_d       = stall_q;
    rd_valid_d    = 1'b0;
    rd_last_d     = 1'b0;
    rd_data_d     = rd_data_q;
    mem_we        = 1'b0;

    if (arm) begin
      // arm wins over everything, including a coincident retire.
      state_d       = PRE;
      wr_ptr_d      = '0;
      count_d       = '0;
      triggered_d   = 1'b0;
      stall_d       = 1'b0;
      stall_cnt_d   = '0;
      last_pc_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        PRE, POST: begin
          if (cpu_valid) begin
            mem_we        = 1'b1;
            wr_ptr_d      = wr_ptr_q + 1'b1;
            count_d       = (count_q == FULL) ? FULL : count_q + 1'b1;
            stall_cnt_d   = stall_cnt_nxt;
            last_pc_d     = cpu_pc;
            last_pc_vld_d = 1'b1;
            if (state_q == PRE) begin
              if (bp_hit || stall_hit) begin
                triggered_d = 1'b1;
                stall_d     = stall_hit;
                post_left_d = POST_INIT;
                if (POST_TRIG == 0) begin
                  state_d = DONE;
                end else begin
                  state_d = POST;
                end
              end
            end else begin
              post_left_d = post_left_q - 1'b1;
              if (post_left_q == POST_ONE) begin
                state_d = DONE;
              end
            end
            // Entering DONE: point the reader at the oldest entry. When the
            // buffer wrapped, that is the slot about to be overwritten next.
            if (state_d == DONE) begin
              rd_ptr_d = (count_d == FULL) ? wr_ptr_d : '0;
            end
          end
        end
        DONE: begin
          if (count_q == CNT_ZERO) begin
            state_d = IDLE;
          end else if (rd_req) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_last_d  = (count_q == CNT_ONE);
            rd_ptr_d   = rd_ptr_q + 1'b1;
            count_d    = count_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      post_left_q   <= '0;
      stall_cnt_q   <= '0;
      last_pc_q     <= '0;
      last_pc_vld_q <= 1'b0;
      triggered_q   <= 1'b0;
      stall_q       <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      post_left_q   <= post_left_d;
      stall_cnt_q   <= stall_cnt_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
      triggered_q   <= triggered_d;
      stall_q       <= stall_d;
      rd_valid_q    <= rd_valid_d;
      rd_last_q     <= rd_last_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Trace storage is not reset; entries are only read back after being written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = (state_q == PRE) || (state_q == POST);
  assign done      = (state_q == DONE);
  assign triggered = triggered_q;
  assign stall     = stall_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trace_capture_monitor.sv
// Directed testbench for trace_capture_monitor (DEPTH=8, POST_TRIG=2,
// STALL_LIMIT=4). Expected entries are pushed into exp_q from hand-written
// PC lists and compared against the readout stream.

module tb_trace_capture_monitor;

  localparam int PC_W        = 8;
  localparam int INSTR_W     = 16;
  localparam int DATA_W      = 8;
  localparam int DEPTH       = 8;
  localparam int POST_TRIG   = 2;
  localparam int STALL_LIMIT = 4;
  localparam int ENTRY_W     = 1 + PC_W + INSTR_W + DATA_W;
  localparam int CW          = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               arm, trig_en, cpu_valid, cpu_rwe, rd_req;
  logic [PC_W-1:0]    trig_pc, cpu_pc;
  logic [INSTR_W-1:0] cpu_instr;
  logic [DATA_W-1:0]  cpu_wdata;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid, rd_last, busy, triggered, stall, done;
  logic [CW-1:0]      count;
  logic [1:0]         dbg_state;

  trace_capture_monitor #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .POST_TRIG(POST_TRIG), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cpu_valid(cpu_valid), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .cpu_rwe(cpu_rwe), .cpu_wdata(cpu_wdata), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .busy(busy),
    .triggered(triggered), .stall(stall), .done(done), .count(count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [ENTRY_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [PC_W-1:0] pc);
    return {pc[0], pc, ~pc, pc, pc ^ 8'h5A};
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [PC_W-1:0] pc);
    cpu_valid = 1'b1;
    cpu_pc    = pc;
    cpu_instr = {~pc, pc};
    cpu_rwe   = pc[0];
    cpu_wdata = pc ^ 8'h5A;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push_pcs(input int first, input int last);
    for (int p = first; p <= last; p++) exp_q.push_back(make_entry(PC_W'(p)));
  endtask

  // Streams the whole buffer with rd_req held high, checks every entry
  // against exp_q, then checks the return to IDLE.
  task automatic read_all(input string tag);
    int cycles;
    int got_n;
    int exp_n;
    bit seen_last;
    logic [ENTRY_W-1:0] e;
    logic [ENTRY_W-1:0] last_e;
    cycles    = 0;
    got_n     = 0;
    seen_last = 1'b0;
    last_e    = '0;
    exp_n     = exp_q.size();
    rd_req    = 1'b1;
    while (!seen_last && cycles < 40) begin
      tick();
      cycles++;
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check($sformatf("%s_extra_entry", tag), 64'(rd_data), 64'(0));
          seen_last = 1'b1;
        end else begin
          e = exp_q.pop_front();
          last_e = e;
          check($sformatf("%s_data%0d", tag, got_n), 64'(rd_data), 64'(e));
          check($sformatf("%s_last%0d", tag, got_n), 64'(rd_last), 64'(exp_q.size() == 0));
          got_n++;
          if (rd_last) seen_last = 1'b1;
        end
      end
    end
    check($sformatf("%s_stream_cycles", tag), 64'(cycles), 64'(exp_n));
    check($sformatf("%s_entries", tag), 64'(got_n), 64'(exp_n));
    tick();
    check($sformatf("%s_idle_state", tag), 64'(dbg_state), 64'(0));
    check($sformatf("%s_idle_done", tag), 64'(done), 64'(0));
    check($sformatf("%s_idle_count", tag), 64'(count), 64'(0));
    check($sformatf("%s_idle_valid", tag), 64'(rd_valid), 64'(0));
    check($sformatf("%s_data_hold", tag), 64'(rd_data), 64'(last_e));
    rd_req = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
    cpu_valid = 1'b0; cpu_pc = '0; cpu_instr = '0; cpu_rwe = 1'b0;
    cpu_wdata = '0; rd_req = 1'b0;
    repeat (3) tick();
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    reset = 1'b1;
    tick();

    // Basic breakpoint capture: PCs 0..5, trigger at 3.
    trig_en = 1'b1; trig_pc = 8'd3;
    do_arm();
    check("t2_busy", 64'(busy), 64'(1));
    check("t2_count0", 64'(count), 64'(0));
    for (int p = 0; p <= 2; p++) retire(PC_W'(p));
    check("t2_pre_trig", 64'(triggered), 64'(0));
    retire(8'd3);
    check("t2_triggered", 64'(triggered), 64'(1));
    check("t2_post_state", 64'(dbg_state), 64'(2));
    retire(8'd4);
    retire(8'd5);
    check("t2_done", 64'(done), 64'(1));
    check("t2_busy_off", 64'(busy), 64'(0));
    check("t2_count", 64'(count), 64'(6));
    check("t2_stall", 64'(stall), 64'(0));
    retire(8'd6);
    check("t2_done_ignores_cpu", 64'(count), 64'(6));
    push_pcs(0, 5);
    read_all("t2");

    // Wrap-around: PCs 0..20, trigger at 12, capture ends after 14.
    trig_pc = 8'd12;
    do_arm();
    for (int p = 0; p <= 20; p++) retire(PC_W'(p));
    check("t3_done", 64'(done), 64'(1));
    check("t3_count", 64'(count), 64'(8));
    check("t3_triggered", 64'(triggered), 64'(1));
    check("t3_stall", 64'(stall), 64'(0));
    push_pcs(7, 14);
    read_all("t3");

    // Stall detection: 5,9,9,9,9 triggers on the 4th PC9.
    trig_en = 1'b0;
    do_arm();
    retire(8'd5); retire(8'd9); retire(8'd9); retire(8'd9);
    check("t4_no_trig_yet", 64'(triggered), 64'(0));
    retire(8'd9);
    check("t4_triggered", 64'(triggered), 64'(1));
    check("t4_stall", 64'(stall), 64'(1));
    check("t4_post_state", 64'(dbg_state), 64'(2));
    retire(8'd10);
    check("t4_not_done", 64'(done), 64'(0));
    retire(8'd11);
    check("t4_done", 64'(done), 64'(1));
    check("t4_count", 64'(count), 64'(7));
    push_pcs(5, 5); push_pcs(9, 9); push_pcs(9, 9); push_pcs(9, 9); push_pcs(9, 9);
    push_pcs(10, 11);
    read_all("t4");

    // Re-arm during POST with a coincident retire of PC 40.
    trig_en = 1'b1; trig_pc = 8'd2;
    do_arm();
    retire(8'd0); retire(8'd1); retire(8'd2);
    check("t5_in_post", 64'(dbg_state), 64'(2));
    arm = 1'b1;
    cpu_valid = 1'b1; cpu_pc = 8'd40; cpu_instr = 16'hBEEF; cpu_rwe = 1'b1; cpu_wdata = 8'h40;
    tick();
    arm = 1'b0; cpu_valid = 1'b0;
    check("t5_busy", 64'(busy), 64'(1));
    check("t5_state_pre", 64'(dbg_state), 64'(1));
    check("t5_count", 64'(count), 64'(0));
    check("t5_triggered", 64'(triggered), 64'(0));
    retire(8'd7);
    check("t5_count1", 64'(count), 64'(1));
    retire(8'd2); retire(8'd3); retire(8'd4);
    check("t5_done", 64'(done), 64'(1));
    check("t5_count4", 64'(count), 64'(4));
    push_pcs(7, 7); push_pcs(2, 4);
    read_all("t5");

    // Asynchronous reset mid-POST, away from any clock edge.
    do_arm();
    retire(8'd0); retire(8'd1); retire(8'd2);
    check("t6_in_post", 64'(dbg_state), 64'(2));
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t6_state", 64'(dbg_state), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_done", 64'(done), 64'(0));
    check("t6_count", 64'(count), 64'(0));
    check("t6_triggered", 64'(triggered), 64'(0));
    check("t6_rd_data", 64'(rd_data), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_rdreq_ignored%0d", i), 64'(rd_valid), 64'(0));
    end
    rd_req = 1'b0;
    check("t6_still_idle", 64'(dbg_state), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
